// File: rtl/dac_output_buffer_if.sv
`default_nettype none
// ============================================================================
// dac_output_buffer_if : AXI-Stream style sample channel into the DAC buffer
// Rev 1.0
// ============================================================================
interface dac_output_buffer_if;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;

   modport master (output s_axis_tdata, output s_axis_tvalid, input s_axis_tready);
   modport slave  (input  s_axis_tdata, input  s_axis_tvalid, output s_axis_tready);
endinterface
`default_nettype wire

// File: rtl/dac_output_buffer.sv
`default_nettype none
// ============================================================================
// dac_output_buffer : elastic sample FIFO that primes, then streams I/Q to DAC
// Rev 1.0
// ============================================================================
module dac_output_buffer #(
   parameter int DEPTH         = 16,
   parameter int PRIME_LEVEL   = 4,
   parameter int PRIME_TIMEOUT = 32,
   parameter int GAP_MAX       = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable_i,
   input  logic                   clear_stats_i,
   input  logic [31:0]            counter_i,
   dac_output_buffer_if.slave     s_axis,
   output logic [15:0]            dac_i_o,
   output logic [15:0]            dac_q_o,
   output logic                   dac_valid_o,
   output logic [$clog2(DEPTH):0] fifo_level_o,
   output logic                   busy_o,
   output logic [31:0]            burst_start_time_o,
   output logic [15:0]            underrun_count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int PC_W  = $clog2(PRIME_TIMEOUT) + 1;
   localparam int GC_W  = $clog2(GAP_MAX) + 1;

   localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] PRIME_LVL  = LVL_W'(PRIME_LEVEL);
   localparam logic [PC_W-1:0]  PRIME_LAST = PC_W'(PRIME_TIMEOUT - 1);
   localparam logic [GC_W-1:0]  GAP_LAST   = GC_W'(GAP_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [PC_W-1:0]   prime_cnt_q, prime_cnt_d;
   logic [GC_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [15:0]       dac_i_q, dac_i_d;
   logic [15:0]       dac_q_q, dac_q_d;
   logic              dac_valid_q, dac_valid_d;
   logic [31:0]       burst_start_q, burst_start_d;
   logic [15:0]       underrun_q, underrun_d;
   logic [31:0]       mem_q [DEPTH];

   logic              w_tready;
   logic              w_push;
   logic              w_pop;
   logic              w_start;
   logic              w_underrun;
   logic [31:0]       w_head;

   // Held low during reset so every output reads 0 while rst_n is asserted.
   assign w_tready = rst_n & enable_i & (level_q < FULL_LVL);
   assign w_push   = s_axis.s_axis_tvalid & w_tready;
   assign w_head   = mem_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      prime_cnt_d = prime_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      w_pop       = 1'b0;
      w_start     = 1'b0;
      w_underrun  = 1'b0;
      if (!enable_i) begin
         state_d     = ST_IDLE;
         prime_cnt_d = '0;
         gap_cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (level_q != '0) begin
                  state_d     = ST_PRIME;
                  prime_cnt_d = '0;
               end
            end
            ST_PRIME: begin
               if ((level_q >= PRIME_LVL) || (prime_cnt_q == PRIME_LAST)) begin
                  state_d     = ST_STREAM;
                  w_start     = 1'b1;
                  prime_cnt_d = '0;
                  gap_cnt_d   = '0;
               end else begin
                  prime_cnt_d = prime_cnt_q + PC_W'(1);
               end
            end
            ST_STREAM: begin
               // A gap is counted once, when data reappears, so a long gap that
               // ends the burst never registers as an underrun.
               if (level_q != '0) begin
                  w_pop      = 1'b1;
                  w_underrun = (gap_cnt_q != '0);
                  gap_cnt_d  = '0;
               end else if (gap_cnt_q == GAP_LAST) begin
                  state_d   = ST_IDLE;
                  gap_cnt_d = '0;
               end else begin
                  gap_cnt_d = gap_cnt_q + GC_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (!enable_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end

      dac_valid_d   = w_pop;
      dac_i_d       = w_pop ? w_head[31:16] : 16'd0;
      dac_q_d       = w_pop ? w_head[15:0]  : 16'd0;
      burst_start_d = w_start ? counter_i : burst_start_q;

      underrun_d = underrun_q;
      if (clear_stats_i) begin
         underrun_d = '0;
      end else if (w_underrun && (underrun_q != 16'hFFFF)) begin
         underrun_d = underrun_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         prime_cnt_q   <= '0;
         gap_cnt_q     <= '0;
         dac_i_q       <= '0;
         dac_q_q       <= '0;
         dac_valid_q   <= 1'b0;
         burst_start_q <= '0;
         underrun_q    <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         prime_cnt_q   <= prime_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         dac_i_q       <= dac_i_d;
         dac_q_q       <= dac_q_d;
         dac_valid_q   <= dac_valid_d;
         burst_start_q <= burst_start_d;
         underrun_q    <= underrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= s_axis.s_axis_tdata;
   end

   assign s_axis.s_axis_tready = w_tready;
   assign dac_i_o              = dac_i_q;
   assign dac_q_o              = dac_q_q;
   assign dac_valid_o          = dac_valid_q;
   assign fifo_level_o         = level_q;
   assign busy_o               = (state_q != ST_IDLE);
   assign burst_start_time_o   = burst_start_q;
   assign underrun_count_o     = underrun_q;
endmodule
`default_nettype wire

// File: tb/tb_dac_output_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_dac_output_buffer : randomized and directed bench against a queue model
// Rev 1.0
// ============================================================================
module tb_dac_output_buffer;
   localparam int DEPTH         = 16;
   localparam int PRIME_LEVEL   = 4;
   localparam int PRIME_TIMEOUT = 32;
   localparam int GAP_MAX       = 8;
   localparam int M_IDLE   = 0;
   localparam int M_PRIME  = 1;
   localparam int M_STREAM = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        clear_stats;
   logic [31:0] counter;
   logic [15:0] dac_i, dac_q, underrun_count;
   logic        dac_valid, busy;
   logic [4:0]  fifo_level;
   logic [31:0] burst_start_time;

   dac_output_buffer_if axis();

   dac_output_buffer #(
      .DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL),
      .PRIME_TIMEOUT(PRIME_TIMEOUT), .GAP_MAX(GAP_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .clear_stats_i(clear_stats),
      .counter_i(counter), .s_axis(axis),
      .dac_i_o(dac_i), .dac_q_o(dac_q), .dac_valid_o(dac_valid),
      .fifo_level_o(fifo_level), .busy_o(busy),
      .burst_start_time_o(burst_start_time), .underrun_count_o(underrun_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue, burst phase plus wait/gap run lengths.
   logic [31:0] m_fifo[$];
   int          m_phase, m_wait, m_gap, m_uc;
   logic        m_valid;
   logic [15:0] m_i, m_q;
   logic [31:0] m_bst;

   function automatic void model_reset();
      m_fifo.delete();
      m_phase = M_IDLE; m_wait = 0; m_gap = 0; m_uc = 0;
      m_valid = 1'b0; m_i = '0; m_q = '0; m_bst = '0;
   endfunction

   function automatic bit model_tready();
      return enable && (m_fifo.size() < DEPTH);
   endfunction

   function automatic bit model_underrun_next();
      return enable && (m_phase == M_STREAM) && (m_fifo.size() > 0) && (m_gap > 0);
   endfunction

   function automatic void model_step();
      logic [31:0] w;
      bit          accept;
      int          lvl;
      m_valid = 1'b0; m_i = '0; m_q = '0;
      if (!enable) begin
         m_fifo.delete();
         m_phase = M_IDLE; m_wait = 0; m_gap = 0;
      end else begin
         lvl    = m_fifo.size();
         accept = axis.s_axis_tvalid && (lvl < DEPTH);
         case (m_phase)
            M_IDLE: if (lvl > 0) begin m_phase = M_PRIME; m_wait = 0; end
            M_PRIME: begin
               if (lvl >= PRIME_LEVEL || m_wait == PRIME_TIMEOUT - 1) begin
                  m_phase = M_STREAM; m_bst = counter; m_gap = 0;
               end else m_wait++;
            end
            default: begin
               if (lvl > 0) begin
                  w = m_fifo.pop_front();
                  m_valid = 1'b1; m_i = w[31:16]; m_q = w[15:0];
                  if (m_gap > 0 && m_uc < 65535) m_uc++;
                  m_gap = 0;
               end else begin
                  m_gap++;
                  if (m_gap == GAP_MAX) begin m_phase = M_IDLE; m_gap = 0; end
               end
            end
         endcase
         if (accept) m_fifo.push_back(axis.s_axis_tdata);
      end
      if (clear_stats) m_uc = 0;
   endfunction

   task automatic check_outputs();
      check_eq("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
      check_eq("dac_valid", 32'(dac_valid), 32'(m_valid));
      check_eq("dac_i", 32'(dac_i), 32'(m_i));
      check_eq("dac_q", 32'(dac_q), 32'(m_q));
      check_eq("busy", 32'(busy), 32'(m_phase != M_IDLE));
      check_eq("burst_start_time", burst_start_time, m_bst);
      check_eq("underrun_count", 32'(underrun_count), 32'(m_uc));
   endtask

   task automatic tick();
      #1;
      check_eq("tready", 32'(axis.s_axis_tready), 32'(model_tready()));
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
      cyc++;
      counter = 32'(cyc) * 32'd13 + 32'h1000_0000;
   endtask

   task automatic drive(input bit v, input logic [31:0] d);
      axis.s_axis_tvalid = v;
      axis.s_axis_tdata  = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, nout, sent, got, ninv, hits, dens, n;
      logic [15:0] uc_keep;
      bit acc;

      rst_n = 1'b0; enable = 1'b0; clear_stats = 1'b0; counter = 32'h1000_0000;
      drive(1'b0, 32'd0);
      model_reset();
      #3;
      check_eq("rst_dac_valid", 32'(dac_valid), 32'd0);
      check_eq("rst_level", 32'(fifo_level), 32'd0);
      check_eq("rst_uc", 32'(underrun_count), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      enable = 1'b1;

      // Prime by level
      first = -1;
      for (int i = 0; i < 24; i++) begin
         drive(i < 4, {16'(i + 1), 16'(i + 2)});
         tick();
         if (i == 3) check_eq("prime_level4", 32'(fifo_level), 32'd4);
         if (i == 5) check_eq("prime_first_sample", {dac_i, dac_q}, 32'h0001_0002);
         if (dac_valid && first < 0) first = i + 1;
      end
      check_eq("prime_first_valid_cycle", 32'(first), 32'd6);
      check_eq("prime_end_idle", 32'(busy), 32'd0);
      check_eq("prime_no_underrun", 32'(underrun_count), 32'd0);

      // Prime timeout with a single word
      nout = 0;
      drive(1'b1, 32'h7FFF_8000);
      tick();
      drive(1'b0, $urandom());
      for (int i = 0; i < 45; i++) begin
         tick();
         if (dac_valid) begin
            nout++;
            check_eq("timeout_sample", {dac_i, dac_q}, 32'h7FFF_8000);
         end
      end
      check_eq("timeout_count", 32'(nout), 32'd1);

      // Disabled input is dropped, then 20 words with the DAC draining
      enable = 1'b0;
      drive(1'b1, $urandom());
      repeat (3) tick();
      check_eq("bp_disabled_level", 32'(fifo_level), 32'd0);
      enable = 1'b1;
      sent = 0; got = 0;
      for (int i = 0; i < 80; i++) begin
         if (sent < 20) drive(1'b1, 32'hA000_0000 + 32'(sent));
         else drive(1'b0, $urandom());
         acc = (sent < 20) && model_tready();
         tick();
         if (acc) sent++;
         if (fifo_level == 5'd16) check_eq("bp_tready_full", 32'(axis.s_axis_tready), 32'd0);
         if (dac_valid) begin
            check_eq("bp_order", {dac_i, dac_q}, 32'hA000_0000 + 32'(got));
            got++;
         end
      end
      check_eq("bp_count", 32'(got), 32'd20);

      // Short underrun then a burst-ending gap
      uc_keep = underrun_count;
      n = 0;
      while ((m_phase != M_STREAM || n < 8) && n < 40) begin
         drive(1'b1, $urandom()); tick(); n++;
      end
      drive(1'b0, $urandom());
      n = 0;
      while (m_fifo.size() > 0 && n < 40) begin tick(); n++; end
      ninv = 0;
      for (int i = 0; i < 3; i++) begin
         drive(i == 2, $urandom());
         tick();
         if (!dac_valid) ninv++;
         check_eq("gap_zero_data", {dac_i, dac_q}, 32'd0);
      end
      check_eq("gap_invalid_cycles", 32'(ninv), 32'd3);
      drive(1'b1, $urandom());
      tick();
      check_eq("underrun_inc", 32'(underrun_count), 32'(uc_keep) + 32'd1);
      check_eq("underrun_still_busy", 32'(busy), 32'd1);
      repeat (5) tick();
      drive(1'b0, $urandom());
      repeat (30) tick();
      check_eq("long_gap_idle", 32'(busy), 32'd0);
      check_eq("long_gap_no_count", 32'(underrun_count), 32'(uc_keep) + 32'd1);

      // Flush mid-burst via enable
      drive(1'b1, $urandom());
      repeat (10) tick();
      uc_keep = underrun_count;
      enable = 1'b0;
      tick();
      check_eq("flush_level", 32'(fifo_level), 32'd0);
      check_eq("flush_busy", 32'(busy), 32'd0);
      check_eq("flush_valid", 32'(dac_valid), 32'd0);
      check_eq("flush_tready", 32'(axis.s_axis_tready), 32'd0);
      check_eq("flush_uc_kept", 32'(underrun_count), 32'(uc_keep));
      enable = 1'b1;
      drive(1'b0, $urandom());
      repeat (20) tick();

      // Stats clear coincident with an underrun event
      hits = 0;
      for (int i = 0; i < 60; i++) begin
         drive(((i / 6) % 2) == 0, $urandom());
         clear_stats = model_underrun_next();
         tick();
         if (clear_stats) begin
            hits++;
            check_eq("clear_priority", 32'(underrun_count), 32'd0);
         end
      end
      clear_stats = 1'b0;
      check_eq("clear_events_seen", 32'(hits > 0), 32'd1);
      drive(1'b0, $urandom());
      repeat (30) tick();

      // Asynchronous reset mid-burst
      drive(1'b1, $urandom());
      repeat (10) tick();
      rst_n = 1'b0;
      #2;
      check_eq("arst_dac", {dac_i, dac_q}, 32'd0);
      check_eq("arst_valid", 32'(dac_valid), 32'd0);
      check_eq("arst_level", 32'(fifo_level), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_bst", burst_start_time, 32'd0);
      check_eq("arst_uc", 32'(underrun_count), 32'd0);
      check_eq("arst_tready", 32'(axis.s_axis_tready), 32'd0);
      model_reset();
      drive(1'b0, $urandom());
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      dens = 80;
      for (int i = 0; i < 1500; i++) begin
         if (i % 200 == 0) dens = $urandom_range(30, 100);
         enable      = ($urandom_range(0, 63) != 0);
         clear_stats = ($urandom_range(0, 49) == 0);
         drive($urandom_range(0, 99) < dens, $urandom());
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
